// File: rtl/alu_bist_ctrl.sv
// BIST initiator for the datapath ALU: LFSR operand pairs, cycling op codes, MISR compaction.
// Optional `ALU_BIST_ABORT_EN adds an abort input that cancels a run in progress.
module alu_bist_ctrl #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] SEED_A      = 32'hACE12468,
    parameter logic [31:0] SEED_B      = 32'h13579BDF,
    parameter logic [31:0] GOLDEN_SIG  = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef ALU_BIST_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_negative
);
    localparam logic [31:0] POLY   = 32'h00400007;
    localparam logic [31:0] SEED_AX = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
    localparam logic [31:0] SEED_BX = (SEED_B == 32'd0) ? 32'd1 : SEED_B;
    localparam logic [15:0] LAST   = 16'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CMP, S_DONE} state_t;

    function automatic logic [31:0] shift_fb(input logic [31:0] q);
        return {q[30:0], 1'b0} ^ (q[31] ? POLY : 32'd0);
    endfunction

    function automatic logic [2:0] op_code(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b000;
            3'd1:    return 3'b001;
            3'd2:    return 3'b010;
            3'd3:    return 3'b011;
            default: return 3'b101;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, sig_q, sig_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  op_q, op_d, ctrl_q, ctrl_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic        abort_req;
    logic [31:0] absorb;

`ifdef ALU_BIST_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign absorb = alu_result ^ {28'd0, alu_overflow, alu_carry, alu_zero, alu_negative};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = SEED_AX;
                    b_d     = SEED_BX;
                    sig_d   = 32'd0;
                    cnt_d   = 16'd0;
                    op_d    = 3'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                // The ALU is combinational, so this edge captures the response to the vector on a/b now.
                sig_d = shift_fb(sig_q) ^ absorb;
                op_d  = (op_q == 3'd4) ? 3'd0 : op_q + 3'd1;
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == LAST) begin
                    state_d = S_CMP;
                end else begin
                    a_d = shift_fb(a_q);
                    b_d = shift_fb(b_q);
                end
            end
            default: begin
                state_d = S_DONE;
                pass_d  = (sig_q == GOLDEN_SIG);
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
        if (abort_req && (state_q == S_RUN || state_q == S_CMP)) begin
            state_d = S_IDLE;
            a_d     = a_q;
            b_d     = b_q;
            sig_d   = sig_q;
            cnt_d   = cnt_q;
            op_d    = op_q;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end
        ctrl_d = op_code(op_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sig_q   <= 32'd0;
            cnt_q   <= 16'd0;
            op_q    <= 3'd0;
            ctrl_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign signature   = sig_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = ctrl_q;
endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: three configurations, a behavioural ALU stub and a loop-based signature model.
module tb_alu_bist_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [31:0] POLY = 32'h00400007;
    localparam logic [31:0] SA   = 32'hACE12468;
    localparam logic [31:0] SB   = 32'h13579BDF;
    localparam logic [31:0] SB6  = 32'h80000000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] step(input logic [31:0] q);
        return {q[30:0], 1'b0} ^ (q[31] ? POLY : 32'd0);
    endfunction

    function automatic logic [31:0] lfsr_n(input logic [31:0] seed, input int k);
        logic [31:0] x = seed;
        for (int i = 0; i < k; i++) x = step(x);
        return x;
    endfunction

    function automatic logic [2:0] opc(input int k);
        case (k % 5)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b010;
            3: return 3'b011;
            default: return 3'b101;
        endcase
    endfunction

    // Behavioural ALU: {overflow, carry, zero, negative, result}
    function automatic logic [35:0] alu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] c, input logic fault);
        logic [32:0] s;
        logic [31:0] r;
        logic v, cy;
        s = 33'd0; r = 32'd0; v = 1'b0; cy = 1'b0;
        case (c)
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32];
                          v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'b001: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; cy = s[32];
                          v = (a[31] != b[31]) && (r[31] != a[31]); end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        if (fault) r[0] = 1'b1;
        return {v, cy, (r == 32'd0), r[31], r};
    endfunction

    function automatic logic [31:0] ref_sig(input int nv, input logic [31:0] sa,
                                            input logic [31:0] sb, input logic fault);
        logic [31:0] a = sa, b = sb, sig = 32'd0;
        logic [35:0] f;
        for (int i = 0; i < nv; i++) begin
            f   = alu(a, b, opc(i), fault);
            sig = step(sig) ^ f[31:0] ^ {28'd0, f[35:32]};
            a   = step(a);
            b   = step(b);
        end
        return sig;
    endfunction

    logic        st1, st6, st256, fault;
    logic        bz1, dn1, ps1, bz6, dn6, ps6, bz256, dn256, ps256;
    logic [31:0] sg1, a1, b1, r1, sg6, a6, b6, r6, sg256, a256, b256, r256;
    logic [2:0]  c1, c6, c256;
    logic        v1, cy1, z1, n1, v6, cy6, z6, n6, v256, cy256, z256, n256;
`ifdef ALU_BIST_ABORT_EN
    logic        ab256;
`endif

    assign {v1, cy1, z1, n1, r1}             = alu(a1, b1, c1, 1'b0);
    assign {v6, cy6, z6, n6, r6}             = alu(a6, b6, c6, 1'b0);
    assign {v256, cy256, z256, n256, r256}   = alu(a256, b256, c256, fault);

    alu_bist_ctrl #(.NUM_VECTORS(1), .SEED_A(32'd5), .SEED_B(32'd3), .GOLDEN_SIG(32'h8)) u1 (
        .clk(clk), .rst(rst), .start(st1),
`ifdef ALU_BIST_ABORT_EN
        .abort(1'b0),
`endif
        .busy(bz1), .done(dn1), .pass(ps1), .signature(sg1), .alu_a(a1), .alu_b(b1),
        .alu_control(c1), .alu_result(r1), .alu_overflow(v1), .alu_carry(cy1),
        .alu_zero(z1), .alu_negative(n1));

    alu_bist_ctrl #(.NUM_VECTORS(6), .SEED_A(32'd5), .SEED_B(SB6), .GOLDEN_SIG(32'h0)) u6 (
        .clk(clk), .rst(rst), .start(st6),
`ifdef ALU_BIST_ABORT_EN
        .abort(1'b0),
`endif
        .busy(bz6), .done(dn6), .pass(ps6), .signature(sg6), .alu_a(a6), .alu_b(b6),
        .alu_control(c6), .alu_result(r6), .alu_overflow(v6), .alu_carry(cy6),
        .alu_zero(z6), .alu_negative(n6));

    alu_bist_ctrl #(.NUM_VECTORS(256), .SEED_A(SA), .SEED_B(SB), .GOLDEN_SIG(32'h0)) u256 (
        .clk(clk), .rst(rst), .start(st256),
`ifdef ALU_BIST_ABORT_EN
        .abort(ab256),
`endif
        .busy(bz256), .done(dn256), .pass(ps256), .signature(sg256), .alu_a(a256), .alu_b(b256),
        .alu_control(c256), .alu_result(r256), .alu_overflow(v256), .alu_carry(cy256),
        .alu_zero(z256), .alu_negative(n256));

    task automatic run256(input string tag);
        int n;
        st256 = 1'b1;
        tick();
        st256 = 1'b0;
        n = 0;
        while (!dn256 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 257);
    endtask

    task automatic chk_zero256(input string tag);
        chk({tag, "_busy"}, bz256, 0);
        chk({tag, "_done"}, dn256, 0);
        chk({tag, "_pass"}, ps256, 0);
        chk({tag, "_sig"}, sg256, 0);
        chk({tag, "_a"}, a256, 0);
        chk({tag, "_b"}, b256, 0);
        chk({tag, "_ctrl"}, c256, 0);
    endtask

    initial begin
        logic [31:0] s6, good;
        int mid;
        st1 = 0; st6 = 0; st256 = 0; fault = 0;
`ifdef ALU_BIST_ABORT_EN
        ab256 = 0;
`endif
        #2 rst = 1'b0;
        #1 chk_zero256("reset");
        tick(); tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("idle_busy", bz1, 0);
        chk("idle_done", dn256, 0);

        // single-vector run
        st1 = 1'b1; tick(); st1 = 1'b0;
        chk("nv1_a", a1, 5);
        chk("nv1_b", b1, 3);
        chk("nv1_ctrl", c1, 0);
        chk("nv1_busy", bz1, 1);
        tick();
        chk("nv1_done_early", dn1, 0);
        tick();
        chk("nv1_done", dn1, 1);
        chk("nv1_pass", ps1, 1);
        chk("nv1_busy_end", bz1, 0);
        chk("nv1_sig", sg1, 32'h8);

        // sequencing, with a stray start pulse mid-run
        repeat ($urandom_range(0, 3)) tick();
        mid = $urandom_range(1, 4);
        st6 = 1'b1; tick(); st6 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("seq_a%0d", k), a6, lfsr_n(32'd5, k));
            chk($sformatf("seq_b%0d", k), b6, lfsr_n(SB6, k));
            chk($sformatf("seq_ctrl%0d", k), c6, opc(k));
            chk($sformatf("seq_done%0d", k), dn6, 0);
            st6 = (k == mid);
            tick();
        end
        st6 = 1'b0;
        chk("seq_cmp_done", dn6, 0);
        chk("seq_cmp_busy", bz6, 1);
        tick();
        s6 = ref_sig(6, 32'd5, SB6, 1'b0);
        chk("seq_done", dn6, 1);
        chk("seq_sig", sg6, s6);
        chk("seq_pass", ps6, (s6 == 32'd0));

        // restart from DONE repeats the run
        st6 = 1'b1; tick(); st6 = 1'b0;
        chk("rerun_done_clr", dn6, 0);
        chk("rerun_pass_clr", ps6, 0);
        chk("rerun_busy", bz6, 1);
        chk("rerun_a", a6, 5);
        repeat (7) tick();
        chk("rerun_done", dn6, 1);
        chk("rerun_sig", sg6, s6);

        // full-length runs, good then faulty ALU
        repeat ($urandom_range(0, 5)) tick();
        good = ref_sig(256, SA, SB, 1'b0);
        run256("good");
        chk("good_sig", sg256, good);
        fault = 1'b1;
        run256("bad");
        chk("bad_sig", sg256, ref_sig(256, SA, SB, 1'b1));
        chk("bad_differs", (sg256 != good), 1);
        chk("bad_pass", ps256, 0);
        chk("bad_done", dn256, 1);

        // asynchronous reset at vector 10
        st256 = 1'b1; tick(); st256 = 1'b0;
        repeat (10) tick();
        chk("mid_busy", bz256, 1);
        #2 rst = 1'b0;
        #1 chk_zero256("midrst");
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("midrst_idle_busy", bz256, 0);
        chk("midrst_idle_done", dn256, 0);

`ifdef ALU_BIST_ABORT_EN
        st256 = 1'b1; tick(); st256 = 1'b0;
        repeat (10) tick();
        ab256 = 1'b1; st256 = 1'b1; tick(); ab256 = 1'b0; st256 = 1'b0;
        chk("abort_busy", bz256, 0);
        chk("abort_done", dn256, 0);
        chk("abort_pass", ps256, 0);
        chk("abort_sig", sg256, ref_sig(10, SA, SB, 1'b1));
        repeat (3) tick();
        chk("abort_idle", bz256, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_bist_ctrl.md
Name: alu_bist_ctrl

Overview:
Built-in self-test initiator for the single-cycle datapath ALU; it is the driving end of the ALU's A/B/ALUControl → Result/flags interface.
- On start, two LFSRs generate operand pairs and the block cycles through the supported ALU operations.
- Each ALU Result and its flags are compacted into a 32-bit MISR signature.
- At the end, the signature is compared against a golden constant and done and pass are reported.
- Sits beside the ALU behind a test mux; the ALU itself is untouched.

Parameters:
NUM_VECTORS, 256, number of ALU operations applied per run; legal range 1..65535.
SEED_A, 32'hACE12468, LFSR_A load value; a seed of 0 is replaced by 1.
SEED_B, 32'h13579BDF, LFSR_B load value; a seed of 0 is replaced by 1.
GOLDEN_SIG, 32'h00000000, expected final signature; set per build from the golden model.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle start pulse
busy  output  1  high in RUN and COMPARE
done  output  1  run finished; held until restart or reset
pass  output  1  signature == GOLDEN_SIG; valid while done=1
signature  output  32  current MISR value
alu_a  output  32  ALU operand A (LFSR_A register)
alu_b  output  32  ALU operand B (LFSR_B register)
alu_control  output  3  ALU operation code
alu_result  input  32  ALU Result
alu_overflow, alu_carry, alu_zero, alu_negative  input  1 each  ALU flags

Behaviour:
- Reset (async, rst=0): state=IDLE; all outputs, LFSRs, MISR, vector counter and op index = 0.
- LFSR step: next = {q[30:0],1'b0} ^ (q[31] ? 32'h00400007 : 0).
- MISR step: sig_next = {sig[30:0],1'b0} ^ (sig[31] ? 32'h00400007 : 0) ^ D.
  - D = alu_result ^ {28'b0, alu_overflow, alu_carry, alu_zero, alu_negative}.
- Op sequence: index 0..4 maps to alu_control 000 (ADD), 001 (SUB), 010 (AND), 011 (OR), 101 (SLT); wraps 4→0.
- All outputs are registered. The ALU is combinational, so the response to the applied vector is sampled on the next rising edge.
- IDLE:
  - start=1 loads LFSR_A=SEED_A, LFSR_B=SEED_B, sig=0, count=0, op index=0, alu_control=000.
  - done=0, pass=0; go to RUN.
- RUN, every cycle:
  - absorb D into the MISR;
  - step both LFSRs;
  - advance op index;
  - count++.
  - On the cycle count==NUM_VECTORS-1 the absorb is performed, the LFSRs are not stepped, and the state moves to COMPARE.
- COMPARE (one cycle): pass <= (sig==GOLDEN_SIG); done <= 1; go to DONE.
- DONE: alu_a, alu_b, alu_control, signature, done and pass are all held. start=1 restarts exactly as from IDLE, and done and pass clear on that edge.
- Latency: done rises NUM_VECTORS+1 cycles after the edge that samples start.
- start in RUN or COMPARE is ignored.
- Reset asserted mid-run aborts immediately to the reset state; no partial done or pass.

Optional Feature:
ALU_BIST_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort=1 in RUN or COMPARE returns to IDLE on that edge with done=0, pass=0, busy=0; signature holds its partial value.
  - abort has priority over start; abort in IDLE or DONE has no effect.
- Undefined: no abort port; a run always completes.

Test Plan:
- Reset: drive rst=0 mid-cycle → all outputs 0 asynchronously; state stays IDLE with start=0 after release.
- NUM_VECTORS=1, SEED_A=5, SEED_B=3, correct ALU, GOLDEN_SIG=32'h00000008:
  - start → next cycle alu_a=5, alu_b=3, alu_control=000, busy=1;
  - signature=8; done=1, pass=1 two cycles after start, busy=0.
- Sequencing, NUM_VECTORS=6, SEED_A=5, SEED_B=32'h80000000:
  - cycle 2: alu_a=0x0000000A, alu_b=0x00400007, alu_control=001;
  - alu_control sequence 000, 001, 010, 011, 101, 000;
  - final signature equals the bench model's value.
- Faulty ALU stub (alu_result[0] stuck at 1), NUM_VECTORS=256, GOLDEN_SIG from the good model → done=1, pass=0, signature≠GOLDEN_SIG.
- Control edges:
  - start pulsed mid-RUN → no restart, done timing unchanged;
  - start in DONE → done and pass drop on the next edge and the run repeats with an identical signature.
- Reset mid-RUN at vector 10 → immediate return to the reset state.
- With ALU_BIST_ABORT_EN, abort at vector 10 → IDLE, done=0, pass=0.
